// File: rtl/recepcao_comando_servos_if.sv
// recepcao_comando_servos_if: serial line in, committed servo positions and debug out
// Ports (slave = receiver side):
//   RX                    serial 7E1 line, idle high
//   pos1..pos3            committed servo positions 0..7
//   novo_comando / erro   one-cycle commit / reject pulses
//   db_dado_recebido_1..3 ASCII digits of the last committed command
//   db_estado             framer state code for the HEX display
interface recepcao_comando_servos_if;
  logic       RX;
  logic [2:0] pos1, pos2, pos3;
  logic       novo_comando, erro;
  logic [6:0] db_dado_recebido_1, db_dado_recebido_2, db_dado_recebido_3;
  logic [3:0] db_estado;
  modport master (
    output RX,
    input  pos1, pos2, pos3, novo_comando, erro,
    input  db_dado_recebido_1, db_dado_recebido_2, db_dado_recebido_3, db_estado
  );
  modport slave (
    input  RX,
    output pos1, pos2, pos3, novo_comando, erro,
    output db_dado_recebido_1, db_dado_recebido_2, db_dado_recebido_3, db_estado
  );
endinterface

// File: rtl/recepcao_comando_servos.sv
// recepcao_comando_servos: 7E1 receiver + "ddd#" framer committing three servo positions atomically
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    recepcao_comando_servos_if.slave (RX in; positions, pulses and debug out)
module recepcao_comando_servos #(
  parameter int CLKS_PER_BIT = 5208
) (
  input logic clock,
  input logic reset,
  recepcao_comando_servos_if.slave bus
);
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARIDADE, PARADA} rx_state_t;
  typedef enum logic [3:0] {
    ESPERA_D1  = 4'd1,
    ESPERA_D2  = 4'd2,
    ESPERA_D3  = 4'd3,
    ESPERA_FIM = 4'd4
  } fr_state_t;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t     rx_st_q, rx_st_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    nbit_q, nbit_d;
  logic [6:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic          char_ok_q, char_ok_d, char_err_q, char_err_d;
  fr_state_t     fr_q, fr_d;
  logic [6:0]    d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [6:0]    db1_q, db1_d, db2_q, db2_d, db3_q, db3_d;
  logic [2:0]    pos1_q, pos1_d, pos2_q, pos2_d, pos3_q, pos3_d;
  logic          novo_q, novo_d, erro_q, erro_d;
  logic          fall, full, is_digit, is_hash;
  // Synchroniser and edge history reset low: a line still low after reset
  // must go idle and fall again before a start is recognised.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= bus.RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  assign fall = rx_prev_q & ~rx_sync_q;
  assign full = timer_q == FULL_M1;
  always_comb begin
    rx_st_d    = rx_st_q;
    timer_d    = timer_q + TW'(1);
    nbit_d     = nbit_q;
    shift_d    = shift_q;
    par_ok_d   = par_ok_q;
    char_ok_d  = 1'b0;
    char_err_d = 1'b0;
    case (rx_st_q)
      OCIOSO: begin
        timer_d = '0;
        rx_st_d = fall ? INICIO : OCIOSO;
      end
      INICIO:
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          nbit_d  = '0;
          rx_st_d = rx_sync_q ? OCIOSO : DADOS;
        end
      DADOS:
        if (full) begin
          timer_d = '0;
          shift_d = {rx_sync_q, shift_q[6:1]};
          nbit_d  = nbit_q + 3'd1;
          rx_st_d = (nbit_q == 3'd6) ? PARIDADE : DADOS;
        end
      PARIDADE:
        if (full) begin
          timer_d  = '0;
          par_ok_d = ~^{shift_q, rx_sync_q};
          rx_st_d  = PARADA;
        end
      PARADA:
        if (full) begin
          timer_d    = '0;
          char_ok_d  = rx_sync_q & par_ok_q;
          char_err_d = ~(rx_sync_q & par_ok_q);
          rx_st_d    = OCIOSO;
        end
      default: rx_st_d = OCIOSO;
    endcase
  end
  // shift_q holds the finished character until the next frame's first data
  // sample, well after the framer consumes it.
  assign is_digit = shift_q[6:3] == 4'b0110;
  assign is_hash  = shift_q == 7'h23;
  always_comb begin
    fr_d   = fr_q;
    d1_d   = d1_q;
    d2_d   = d2_q;
    d3_d   = d3_q;
    db1_d  = db1_q;
    db2_d  = db2_q;
    db3_d  = db3_q;
    pos1_d = pos1_q;
    pos2_d = pos2_q;
    pos3_d = pos3_q;
    novo_d = 1'b0;
    erro_d = 1'b0;
    if (char_err_q) begin
      erro_d = 1'b1;
      fr_d   = ESPERA_D1;
    end else if (char_ok_q) begin
      case (fr_q)
        ESPERA_D1: begin
          d1_d   = shift_q;
          fr_d   = is_digit ? ESPERA_D2 : ESPERA_D1;
          erro_d = ~is_digit;
        end
        ESPERA_D2: begin
          d2_d   = shift_q;
          fr_d   = is_digit ? ESPERA_D3 : ESPERA_D1;
          erro_d = ~is_digit;
        end
        ESPERA_D3: begin
          d3_d   = shift_q;
          fr_d   = is_digit ? ESPERA_FIM : ESPERA_D1;
          erro_d = ~is_digit;
        end
        default: begin
          fr_d   = ESPERA_D1;
          erro_d = ~is_hash;
          novo_d = is_hash;
          if (is_hash) begin
            pos1_d = d1_q[2:0];
            pos2_d = d2_q[2:0];
            pos3_d = d3_q[2:0];
            db1_d  = d1_q;
            db2_d  = d2_q;
            db3_d  = d3_q;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rx_st_q    <= OCIOSO;
      timer_q    <= '0;
      nbit_q     <= '0;
      shift_q    <= '0;
      par_ok_q   <= 1'b0;
      char_ok_q  <= 1'b0;
      char_err_q <= 1'b0;
      fr_q       <= ESPERA_D1;
      d1_q       <= 7'h30;
      d2_q       <= 7'h30;
      d3_q       <= 7'h30;
      db1_q      <= 7'h30;
      db2_q      <= 7'h30;
      db3_q      <= 7'h30;
      pos1_q     <= '0;
      pos2_q     <= '0;
      pos3_q     <= '0;
      novo_q     <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      rx_st_q    <= rx_st_d;
      timer_q    <= timer_d;
      nbit_q     <= nbit_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      char_ok_q  <= char_ok_d;
      char_err_q <= char_err_d;
      fr_q       <= fr_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      d3_q       <= d3_d;
      db1_q      <= db1_d;
      db2_q      <= db2_d;
      db3_q      <= db3_d;
      pos1_q     <= pos1_d;
      pos2_q     <= pos2_d;
      pos3_q     <= pos3_d;
      novo_q     <= novo_d;
      erro_q     <= erro_d;
    end
  assign bus.pos1               = pos1_q;
  assign bus.pos2               = pos2_q;
  assign bus.pos3               = pos3_q;
  assign bus.db_dado_recebido_1 = db1_q;
  assign bus.db_dado_recebido_2 = db2_q;
  assign bus.db_dado_recebido_3 = db3_q;
  assign bus.novo_comando       = novo_q;
  assign bus.erro               = erro_q;
  assign bus.db_estado          = fr_q;
endmodule

// File: doc/recepcao_comando_servos.md
# recepcao_comando_servos

Serial command receiver feeding the servo position registers of the robot top level. Deserialises 7E1 ASCII characters from `RX`, assembles a four-character command of three position digits plus a `#` terminator, and commits the three servo positions atomically. Also exposes the last accepted characters for the HEX debug displays. Malformed characters or commands are discarded whole and flagged.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit (50 MHz / 9600 baud); minimum 4.

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `RX`  in  1  serial line; idle high; asynchronous to `clock`.
- `pos1`, `pos2`, `pos3`  out  3 each  committed servo positions, 0..7.
- `novo_comando`  out  1  one-cycle pulse when new positions are committed.
- `erro`  out  1  one-cycle pulse when a character or command is rejected.
- `db_dado_recebido_1`, `_2`, `_3`  out  7 each  ASCII digits of the last committed command.
- `db_estado`  out  4  framer state code for the HEX display.

## Operation
- `RX` passes through a 2-flop synchroniser; only the synchronised value is used.
- Receiver states: OCIOSO, INICIO, DADOS, PARIDADE, PARADA.
  - OCIOSO: a 1->0 transition on synchronised RX -> INICIO, bit timer cleared.
  - INICIO: at `CLKS_PER_BIT/2` the line is resampled; 0 -> DADOS; 1 -> false start, back to OCIOSO, no `erro`.
  - DADOS: 7 samples, one every `CLKS_PER_BIT` cycles, LSB first, into a 7-bit shift register.
  - PARIDADE: one sample; even parity required (data bits XOR parity bit = 0).
  - PARADA: one sample; must be 1. The receiver then returns to OCIOSO and raises an internal one-cycle `char_ok` or `char_err`.
  - Parity or stop failure produces `char_err`.
  - A start edge is accepted immediately after the stop sample, so back-to-back characters with exactly one stop bit are received.
- Framer states and `db_estado` codes: ESPERA_D1 = 1, ESPERA_D2 = 2, ESPERA_D3 = 3, ESPERA_FIM = 4.
  - On `char_ok` with a digit `'0'`..`'7'` (0x30..0x37) in ESPERA_Dn: the digit is stored in temporary slot n and the framer advances.
  - On `char_ok` with `'#'` (0x23) in ESPERA_FIM:
    - `posN` <= temporary slot N bits [2:0];
    - `db_dado_recebido_N` <= temporary slot N (full 7-bit ASCII);
    - `novo_comando` pulses;
    - the framer returns to ESPERA_D1.
  - Rejected, with `erro` pulsed and the framer sent to ESPERA_D1:
    - any `char_err`;
    - a non-digit character in ESPERA_D1..D3, including `'#'` or `'8'`;
    - a non-`'#'` character in ESPERA_FIM.

    Committed outputs are unchanged by a rejection; temporary slots may hold stale data.
- `novo_comando` and `erro` are never high together.

## Timing
- Reset values:
  - all `pos*` = 0; `db_dado_recebido_*` = 7'h30 (`'0'`);
  - `novo_comando` = 0; `erro` = 0;
  - receiver in OCIOSO; framer in ESPERA_D1, so `db_estado` = 1.
- Reset mid-frame aborts the frame; the line must return to idle and present a new start edge before reception resumes.
- Synchroniser latency: 2 cycles.
- Start-edge detection to mid-start sample: `CLKS_PER_BIT/2` cycles. Consecutive bit samples are `CLKS_PER_BIT` cycles apart.
- `char_ok`/`char_err` are registered 1 cycle after the stop-bit sample.
- `posN`, `db_dado_recebido_N`, `novo_comando` and `erro` all update on the cycle after `char_ok`/`char_err`, i.e. 2 cycles after the stop sample of the deciding character.
- Positions stay constant between commits; there is no handshake. Consumers use `novo_comando` or sample `posN` directly.
- A glitch low shorter than `CLKS_PER_BIT/2` cycles is ignored: it causes a false start with no `erro`.

## Test plan
Benches use `CLKS_PER_BIT` = 8.
- Reset and sent `"357#"` as 7E1 frames (for `'3'`: 0x33, parity 0) -> exactly one `novo_comando` pulse; `pos1/2/3` = 3/5/7; `db_dado_recebido_*` = 0x33/0x35/0x37; `db_estado` back to 1.
- After the above, `"2#"` -> `erro` pulses on `'#'`; `pos*` stay 3/5/7; the next `"012#"` commits 0/1/2.
- `'4'` sent with the parity bit flipped, then `"44#"` -> `erro` on the first character; the remaining `"44#"` then fails at `'#'` in ESPERA_D3 (second `erro`); no commit.
- `"1239"` then `"765#"` -> `erro` on `'9'`; then commit 7/6/5 with one `novo_comando`.
- RX low pulse of 3 cycles while idle -> no `erro`, no state change. Then `"111#"` with zero idle gap between frames -> commit 1/1/1.
- Reset asserted mid-data-bit of the second digit of `"56"`, released, then `"000#"` -> outputs at reset values during reset; then commit 0/0/0 with `novo_comando`.
